// File: rtl/mux4to1b4.sv
// 4:1 mux of WIDTH-bit inputs with a combinational output (O) and an en-gated
// registered copy (Q, sel_q, valid). Define MUX4TO1B4_PARITY_EN to add registered parity (par).
module mux4to1b4 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       ctrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   input  logic             en,
   output logic [WIDTH-1:0] O,
   output logic [WIDTH-1:0] Q,
   output logic [1:0]       sel_q,
   output logic             valid
`ifdef MUX4TO1B4_PARITY_EN
   ,
   output logic             par
`endif
);

   logic [WIDTH-1:0] o_c;
   logic [WIDTH-1:0] q_d, q_q;
   logic [1:0]       sel_d, sel_q_q;
   logic             valid_d, valid_q;

   // Select path: all four codes are listed, so no fallback branch is needed.
   always_comb begin
      o_c = A;
      unique case (ctrl)
         2'b00: o_c = A;
         2'b01: o_c = B;
         2'b10: o_c = C;
         2'b11: o_c = D;
      endcase
   end

   always_comb begin
      q_d     = q_q;
      sel_d   = sel_q_q;
      valid_d = en;
      if (en) begin
         q_d   = o_c;
         sel_d = ctrl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q     <= '0;
         sel_q_q <= 2'b00;
         valid_q <= 1'b0;
      end else begin
         q_q     <= q_d;
         sel_q_q <= sel_d;
         valid_q <= valid_d;
      end
   end

`ifdef MUX4TO1B4_PARITY_EN
   logic par_d, par_q;

   // Parity is captured alongside Q, so it always matches the XOR of Q.
   always_comb begin
      par_d = par_q;
      if (en) par_d = ^o_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= par_d;
   end

   assign par = par_q;
`endif

   assign O     = o_c;
   assign Q     = q_q;
   assign sel_q = sel_q_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_mux4to1b4.sv
// Self-checking bench for mux4to1b4: directed scenarios plus randomized traffic
// compared against an array-indexed reference model.
module tb_mux4to1b4;
   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   ctrl = 2'b00;
   logic [W-1:0] A = '0, B = '0, C = '0, D = '0;
   logic         en = 1'b0;
   logic [W-1:0] O, Q;
   logic [1:0]   sel_q;
   logic         valid;
`ifdef MUX4TO1B4_PARITY_EN
   logic         par;
`endif

   int errors = 0;
   int checks = 0;

   logic [W-1:0] exp_q = '0;
   logic [1:0]   exp_sel = 2'b00;
   logic         exp_valid = 1'b0;

   mux4to1b4 #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .ctrl(ctrl),
      .A(A), .B(B), .C(C), .D(D), .en(en),
      .O(O), .Q(Q), .sel_q(sel_q), .valid(valid)
`ifdef MUX4TO1B4_PARITY_EN
      , .par(par)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] ref_mux(input logic [1:0] s);
      logic [W-1:0] d [4];
      d[0] = A; d[1] = B; d[2] = C; d[3] = D;
      return d[s];
   endfunction

   // Advance one rising edge, updating the model from the values present at that edge.
   task automatic step();
      @(posedge clk);
      if (!rst_n) begin
         exp_q = '0; exp_sel = 2'b00; exp_valid = 1'b0;
      end else begin
         if (en) begin
            exp_q   = ref_mux(ctrl);
            exp_sel = ctrl;
         end
         exp_valid = en;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; ctrl = 2'b11; D = 4'b1111;
      #1;
      checks++; if (Q !== 4'b0000) begin errors++; $display("FAIL reset_q got=%b exp=0000", Q); end
      checks++; if (sel_q !== 2'b00) begin errors++; $display("FAIL reset_sel got=%b exp=00", sel_q); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
      step();
      checks++; if (Q !== 4'b0000 || valid !== 1'b0) begin errors++; $display("FAIL reset_hold q=%b valid=%b exp=0000/0", Q, valid); end
      @(negedge clk);
      en = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_comb_mux();
      logic [W-1:0] exp;
      A = 4'b0001; B = 4'b0010; C = 4'b0100; D = 4'b1000; en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ctrl = 2'(i);
         #1;
         exp = 4'b0001 << i;
         checks++; if (O !== exp) begin errors++; $display("FAIL comb_mux ctrl=%0d got=%b exp=%b", i, O, exp); end
         #49;
      end
   endtask

   task automatic test_capture();
      @(negedge clk); ctrl = 2'b10; en = 1'b1;
      step();
      checks++; if (Q !== 4'b0100) begin errors++; $display("FAIL capture_q got=%b exp=0100", Q); end
      checks++; if (sel_q !== 2'b10) begin errors++; $display("FAIL capture_sel got=%b exp=10", sel_q); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL capture_valid got=%b exp=1", valid); end
   endtask

   task automatic test_hold();
      @(negedge clk); en = 1'b0; ctrl = 2'b11;
      step();
      checks++; if (Q !== 4'b0100 || sel_q !== 2'b10) begin errors++; $display("FAIL hold_q q=%b sel=%b exp=0100/10", Q, sel_q); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_valid got=%b exp=0", valid); end
      checks++; if (O !== 4'b1000) begin errors++; $display("FAIL hold_o got=%b exp=1000", O); end
   endtask

   task automatic test_wrap();
      @(negedge clk); en = 1'b1; ctrl = 2'b11;
      step();
      checks++; if (Q !== 4'b1000 || sel_q !== 2'b11) begin errors++; $display("FAIL wrap_d q=%b sel=%b exp=1000/11", Q, sel_q); end
      @(negedge clk); ctrl = 2'b00;
      step();
      checks++; if (Q !== 4'b0001 || sel_q !== 2'b00 || valid !== 1'b1) begin
         errors++; $display("FAIL wrap_a q=%b sel=%b valid=%b exp=0001/00/1", Q, sel_q, valid);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk); en = 1'b1; ctrl = 2'b11;
      step();
      @(negedge clk); en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      exp_q = '0; exp_sel = 2'b00; exp_valid = 1'b0;
      checks++; if (Q !== 4'b0000 || sel_q !== 2'b00 || valid !== 1'b0) begin
         errors++; $display("FAIL async_reset q=%b sel=%b valid=%b exp=0000/00/0", Q, sel_q, valid);
      end
      ctrl = 2'b01; #1;
      checks++; if (O !== 4'b0010) begin errors++; $display("FAIL reset_o got=%b exp=0010", O); end
      en = 1'b1;
      step();
      checks++; if (Q !== 4'b0000 || valid !== 1'b0) begin errors++; $display("FAIL reset_discard q=%b valid=%b exp=0000/0", Q, valid); end
      @(negedge clk); rst_n = 1'b1; ctrl = 2'b10;
      step();
      checks++; if (Q !== 4'b0100 || sel_q !== 2'b10 || valid !== 1'b1) begin
         errors++; $display("FAIL post_reset q=%b sel=%b valid=%b exp=0100/10/1", Q, sel_q, valid);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         A = W'($urandom); B = W'($urandom); C = W'($urandom); D = W'($urandom);
         ctrl = 2'($urandom); en = 1'($urandom);
         #1;
         checks++; if (O !== ref_mux(ctrl)) begin errors++; $display("FAIL rand_o n=%0d got=%b exp=%b", n, O, ref_mux(ctrl)); end
         step();
         checks++; if (Q !== exp_q || sel_q !== exp_sel || valid !== exp_valid) begin
            errors++; $display("FAIL rand_regs n=%0d got=%b/%b/%b exp=%b/%b/%b", n, Q, sel_q, valid, exp_q, exp_sel, exp_valid);
         end
`ifdef MUX4TO1B4_PARITY_EN
         checks++; if (par !== ^exp_q) begin errors++; $display("FAIL rand_par n=%0d got=%b exp=%b", n, par, ^exp_q); end
`endif
      end
   endtask

`ifdef MUX4TO1B4_PARITY_EN
   task automatic test_parity();
      @(negedge clk); A = 4'b0111; ctrl = 2'b00; en = 1'b1;
      step();
      checks++; if (par !== 1'b1) begin errors++; $display("FAIL parity_a got=%b exp=1", par); end
      @(negedge clk); B = 4'b0011; ctrl = 2'b01;
      step();
      checks++; if (par !== 1'b0) begin errors++; $display("FAIL parity_b got=%b exp=0", par); end
   endtask
`endif

   initial begin
      test_reset();
      test_comb_mux();
      test_capture();
      test_hold();
      test_wrap();
      test_async_reset();
      test_random();
`ifdef MUX4TO1B4_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
